// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC multiplexed bus cycle engine.
// Cycle counts are in clk periods; the top module takes them as parameters.
package rtc_bus_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_A_SET,
      S_A_STB,
      S_A_HLD,
      S_GAP,
      S_D_SET,
      S_D_STB,
      S_D_HLD,
      S_DONE,
      S_ABRT
   } state_t;

   localparam int T_SETUP_DEF = 2;
   localparam int T_PW_DEF    = 10;
   localparam int T_HOLD_DEF  = 2;
   localparam int T_GAP_DEF   = 4;

endpackage

// File: rtl/rtc_bus_cycle.sv
// Multiplexed address/data bus cycle generator for an external RTC chip.
// Optional abort input enabled with `define RTC_BUS_ABORT_EN.
module rtc_bus_cycle
   import rtc_bus_pkg::*;
#(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_PW    = T_PW_DEF,
   parameter int T_HOLD  = T_HOLD_DEF,
   parameter int T_GAP   = T_GAP_DEF
) (
   input  logic       clk,
   input  logic       reset,
`ifdef RTC_BUS_ABORT_EN
   input  logic       abort,
`endif
   input  logic       start,
   input  logic       w_r,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       a_d,
   output logic       cs,
   output logic       rd,
   output logic       wr,
   output logic       send_add,
   output logic       send_data,
   output logic       read_data,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done
);

   state_t     state, state_n;
   logic [7:0] cnt;
   logic       start_q, launch;
   logic       w_r_q, w_r_n;
   logic [7:0] addr_q, addr_n, wdata_q, wdata_n;
   logic [7:0] ad_out_n;
   logic       ad_oe_n, a_d_n, cs_n, rd_n, wr_n;
   logic       sa_n, sd_n, rdf_n, busy_n, done_n;

   function automatic logic [7:0] dur(state_t s);
      unique case (s)
         S_A_SET, S_D_SET: dur = 8'(T_SETUP - 1);
         S_A_STB, S_D_STB: dur = 8'(T_PW - 1);
         S_A_HLD, S_D_HLD: dur = 8'(T_HOLD - 1);
         S_GAP:            dur = 8'(T_GAP - 1);
         default:          dur = '0;
      endcase
   endfunction

   assign launch  = (state == S_IDLE) && start && !start_q;
   assign w_r_n   = launch ? w_r   : w_r_q;
   assign addr_n  = launch ? addr  : addr_q;
   assign wdata_n = launch ? wdata : wdata_q;

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (launch) state_n = S_A_SET;
         S_A_SET: if (cnt == '0) state_n = S_A_STB;
         S_A_STB: if (cnt == '0) state_n = S_A_HLD;
         S_A_HLD: if (cnt == '0) state_n = S_GAP;
         S_GAP:   if (cnt == '0) state_n = S_D_SET;
         S_D_SET: if (cnt == '0) state_n = S_D_STB;
         S_D_STB: if (cnt == '0) state_n = S_D_HLD;
         S_D_HLD: if (cnt == '0) state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
`ifdef RTC_BUS_ABORT_EN
      if (abort && state != S_IDLE && state != S_ABRT)
         state_n = S_ABRT;
`endif
   end

   // Outputs decoded from the next state so every pin comes straight off a flop.
   always_comb begin
      ad_out_n = ad_out;
      ad_oe_n  = 1'b0;
      a_d_n    = 1'b1;
      cs_n     = 1'b1;
      rd_n     = 1'b1;
      wr_n     = 1'b1;
      sa_n     = 1'b0;
      sd_n     = 1'b0;
      rdf_n    = 1'b0;
      busy_n   = (state_n != S_IDLE);
      done_n   = (state_n == S_DONE);
      unique case (state_n)
         S_A_SET, S_A_STB, S_A_HLD: begin
            a_d_n    = 1'b0;
            cs_n     = 1'b0;
            ad_out_n = addr_n;
            ad_oe_n  = 1'b1;
            if (state_n == S_A_STB) begin
               wr_n = 1'b0;
               sa_n = 1'b1;
            end
         end
         S_D_SET, S_D_STB, S_D_HLD: begin
            cs_n = 1'b0;
            if (w_r_n) begin
               ad_out_n = wdata_n;
               ad_oe_n  = 1'b1;
            end
            if (state_n == S_D_STB) begin
               wr_n  = !w_r_n;
               rd_n  = w_r_n;
               sd_n  = w_r_n;
               rdf_n = !w_r_n;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
         w_r_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state   <= state_n;
         start_q <= start;
         w_r_q   <= w_r_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         if (state_n != state)
            cnt <= dur(state_n);
         else if (cnt != '0)
            cnt <= cnt - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ad_out    <= '0;
         ad_oe     <= 1'b0;
         a_d       <= 1'b1;
         cs        <= 1'b1;
         rd        <= 1'b1;
         wr        <= 1'b1;
         send_add  <= 1'b0;
         send_data <= 1'b0;
         read_data <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rdata     <= '0;
      end else begin
         ad_out    <= ad_out_n;
         ad_oe     <= ad_oe_n;
         a_d       <= a_d_n;
         cs        <= cs_n;
         rd        <= rd_n;
         wr        <= wr_n;
         send_add  <= sa_n;
         send_data <= sd_n;
         read_data <= rdf_n;
         busy      <= busy_n;
         done      <= done_n;
         if (state == S_D_STB && state_n == S_D_HLD && !w_r_q)
            rdata <= ad_in;
      end
   end

endmodule
